// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, one bit per clock.
// A start in IDLE or DONE loads the operands; the result, carry and overflow are updated together at the end of the pass.

module fullAdder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iSub,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oSum,
    output logic             oCout,
    output logic             oOvf
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-2:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, done_q;
    logic               fa_s, fa_co;
    logic [WIDTH-1:0]   res_full;

    fullAdder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_co)
    );

    // The new sum bit enters at the top; after WIDTH shifts the LSB has reached bit 0.
    assign res_full = {fa_s, res_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (iStart) begin
                    // Subtract is A + ~B + 1: the +1 enters through the carry preload.
                    a_d     = iA;
                    b_d     = iSub ? ~iB : iB;
                    carry_d = iSub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_full[WIDTH-1:1];
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB.
                    sum_d   = res_full;
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= (state_q == RUN);
            done_q  <= (state_q == DONE);
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge iClk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
    end

    assign oBusy = busy_q;
    assign oDone = done_q;
    assign oSum  = sum_q;
    assign oCout = cout_q;
    assign oOvf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8): a timing/arithmetic model checked every cycle,
// plus directed operations with hand-computed results.

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic         iStart = 1'b0;
    logic         iSub = 1'b0;
    logic [W-1:0] iA = '0;
    logic [W-1:0] iB = '0;
    logic         oBusy, oDone, oCout, oOvf;
    logic [W-1:0] oSum;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iStart (iStart),
        .iSub   (iSub),
        .iA     (iA),
        .iB     (iB),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oSum   (oSum),
        .oCout  (oCout),
        .oOvf   (oOvf)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: an operation accepted at edge t is in flight for edges t+1..t+W,
    // its result appears after edge t+W and done is seen after edge t+W+1.
    int           ecnt = 0;
    int           acc_t = -1;
    logic [W-1:0] m_a, m_b;
    logic         m_sub;
    logic         m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] m_sum = '0;
    bit           mdl_valid = 1'b0;

    task automatic model_result();
        int sa, sb, sr;
        sa = int'($signed(m_a));
        sb = int'($signed(m_b));
        if (m_sub) begin
            m_sum  = W'(int'(m_a) - int'(m_b));
            m_cout = (m_a >= m_b);
            sr     = sa - sb;
        end else begin
            m_sum  = W'(int'(m_a) + int'(m_b));
            m_cout = ((int'(m_a) + int'(m_b)) >= (1 << W));
            sr     = sa + sb;
        end
        m_ovf = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    endtask

    always @(posedge iClk) begin
        ecnt++;
        if (iRst) begin
            acc_t  = -1;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_done = (acc_t >= 0) && (ecnt == acc_t + W + 1);
            m_busy = (acc_t >= 0) && (ecnt >= acc_t + 1) && (ecnt <= acc_t + W);
            if (acc_t >= 0 && ecnt == acc_t + W)
                model_result();
            if (iStart && !m_busy) begin
                acc_t = ecnt;
                m_a   = iA;
                m_b   = iB;
                m_sub = iSub;
            end
        end
        mdl_valid = 1'b1;
    end

    always @(negedge iClk) begin
        if (mdl_valid) begin
            chk("model busy", 32'(oBusy), 32'(m_busy));
            chk("model done", 32'(oDone), 32'(m_done));
            chk("model sum",  32'(oSum),  32'(m_sum));
            chk("model cout", 32'(oCout), 32'(m_cout));
            chk("model ovf",  32'(oOvf),  32'(m_ovf));
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input string tag);
        int busy_n = 0;
        int done_k = -1;
        logic [W-1:0] s = '0;
        logic c = 1'b0, o = 1'b0;
        @(negedge iClk);
        iRst = 1'b0; iStart = 1'b1; iA = a; iB = b; iSub = sub;
        @(negedge iClk);
        iStart = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge iClk);
            if (oBusy) busy_n++;
            if (oDone && done_k < 0) begin
                done_k = k;
                s = oSum; c = oCout; o = oOvf;
            end
        end
        chk({tag, " latency"}, 32'(done_k), 32'(W + 2));
        chk({tag, " busy cycles"}, 32'(busy_n), 32'(W));
        chk({tag, " sum"}, 32'(s), 32'(es));
        chk({tag, " cout"}, 32'(c), 32'(ec));
        chk({tag, " ovf"}, 32'(o), 32'(eo));
    endtask

    initial begin
        int nd, first, last, idle_n;
        logic [W-1:0] s;

        repeat (3) @(negedge iClk);
        chk("reset busy", 32'(oBusy), 32'd0);
        chk("reset done", 32'(oDone), 32'd0);
        chk("reset sum",  32'(oSum),  32'd0);
        chk("reset cout", 32'(oCout), 32'd0);
        chk("reset ovf",  32'(oOvf),  32'd0);

        // The first start coincides with reset release.
        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add 5A+3C");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add FF+01");
        run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub 10-20");
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub 80-01");

        // Start pulse during the third RUN cycle must be ignored.
        @(negedge iClk);
        iStart = 1'b1; iA = 8'h11; iB = 8'h22; iSub = 1'b0;
        nd = 0; s = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge iClk);
            if (oDone) begin nd++; s = oSum; end
            if (k == 1) iStart = 1'b0;
            if (k == 3) begin iStart = 1'b1; iA = 8'h77; iB = 8'h77; iSub = 1'b1; end
            if (k == 4) iStart = 1'b0;
        end
        chk("ignore done count", 32'(nd), 32'd1);
        chk("ignore sum", 32'(s), 32'h33);

        // Start held high: back-to-back operations.
        @(negedge iClk);
        iStart = 1'b1; iA = 8'h03; iB = 8'h04; iSub = 1'b0;
        nd = 0; first = -1; last = -1; idle_n = 0; s = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge iClk);
            if (oDone) begin
                if (last >= 0) chk("b2b period", 32'(k - last), 32'd9);
                if (first < 0) first = k;
                last = k;
                nd++;
                s = oSum;
            end
            if (first >= 0 && !oBusy && !oDone) idle_n++;
        end
        iStart = 1'b0;
        chk("b2b done count", 32'(nd), 32'd4);
        chk("b2b idle cycles", 32'(idle_n), 32'd0);
        chk("b2b sum", 32'(s), 32'h07);
        repeat (12) @(negedge iClk);

        // Reset in the fourth RUN cycle abandons the operation.
        @(negedge iClk);
        iStart = 1'b1; iA = 8'h5A; iB = 8'h3C; iSub = 1'b0;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (3) @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        chk("abort busy", 32'(oBusy), 32'd0);
        chk("abort done", 32'(oDone), 32'd0);
        chk("abort sum",  32'(oSum),  32'd0);
        chk("abort cout", 32'(oCout), 32'd0);
        chk("abort ovf",  32'(oOvf),  32'd0);
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge iClk);
            if (oDone) nd++;
        end
        chk("abort no done", 32'(nd), 32'd0);
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "post-abort sub");

        repeat (2) @(negedge iClk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
